// File: rtl/ahb3lite_gpio.sv
// AHB3-Lite GPIO slave: latched LED outputs, debounced button inputs, sticky rising-edge flags.
// Optional GPIO_IRQ_EN macro adds the IRQ_MASK register at 0x14 and the irq_o output.
module ahb3lite_gpio #(
  parameter int          g_haddr_size       = 32,
  parameter int          g_hdata_size       = 32,
  parameter int          g_width            = 8,
  parameter logic [15:0] g_debounce_default = 16'd9999,
  parameter logic [31:0] g_id               = 32'h6770_0001
) (
  input  logic                    hclk_i,
  input  logic                    rst_i,
  input  logic                    hsel_i,
  input  logic [g_haddr_size-1:0] haddr_i,
  input  logic [g_hdata_size-1:0] hwdata_i,
  output logic [g_hdata_size-1:0] hrdata_o,
  input  logic                    hwrite_i,
  input  logic [2:0]              hsize_i,
  input  logic [2:0]              hburst_i,
  input  logic [3:0]              hprot_i,
  input  logic [1:0]              htrans_i,
  input  logic                    hready_i,
  output logic                    hreadyout_o,
  output logic                    hresp_o,
  input  logic [g_width-1:0]      gpio_i,
  output logic [g_width-1:0]      gpio_o
`ifdef GPIO_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

  state_t             state;
  logic               accept;
  logic               mapped;
  logic               legal;
  logic [2:0]         offset;
  logic               dp_valid;
  logic               dp_write;
  logic [2:0]         dp_offset;
  logic               wr;
  logic [g_width-1:0] out_reg;
  logic [g_width-1:0] in_reg;
  logic [g_width-1:0] edge_reg;
  logic [15:0]        debounce;
  logic [15:0]        cnt;
  logic               tick;
  logic [g_width-1:0] sync1;
  logic [g_width-1:0] s;
  logic [g_width-1:0] smp;
  logic [g_width-1:0] match;
  logic [g_width-1:0] edge_set;
  logic [g_width-1:0] edge_clr;
  logic               unused_bits;
`ifdef GPIO_IRQ_EN
  logic [g_width-1:0] irq_mask;
`endif

  assign unused_bits = ^{hburst_i, hprot_i, haddr_i, hwdata_i};

  assign accept = hsel_i & hready_i & htrans_i[1];
  assign offset = haddr_i[4:2];

  always_comb begin
    mapped = (offset <= 3'd4);
`ifdef GPIO_IRQ_EN
    if (offset == 3'd5) mapped = 1'b1;
`endif
  end

  assign legal = (hsize_i == 3'b010) && mapped;

  // Only legal transfers open a data phase; illegal ones are handled by the response FSM.
  always_ff @(posedge hclk_i or posedge rst_i) begin
    if (rst_i) begin
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_offset <= 3'd0;
    end else begin
      dp_valid <= accept & legal;
      if (accept) begin
        dp_write  <= hwrite_i;
        dp_offset <= offset;
      end
    end
  end

  always_ff @(posedge hclk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      hreadyout_o <= 1'b1;
      hresp_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !legal) begin
            state       <= ERR1;
            hreadyout_o <= 1'b0;
            hresp_o     <= 1'b1;
          end
        end
        ERR1: begin
          state       <= ERR2;
          hreadyout_o <= 1'b1;
          hresp_o     <= 1'b1;
        end
        ERR2: begin
          if (accept && !legal) begin
            state       <= ERR1;
            hreadyout_o <= 1'b0;
            hresp_o     <= 1'b1;
          end else begin
            state       <= IDLE;
            hreadyout_o <= 1'b1;
            hresp_o     <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          hreadyout_o <= 1'b1;
          hresp_o     <= 1'b0;
        end
      endcase
    end
  end

  assign wr       = dp_valid & dp_write;
  assign tick     = (cnt == 16'd0);
  assign match    = ~(s ^ smp);
  assign edge_set = tick ? (match & s & ~in_reg) : '0;
  assign edge_clr = (wr && dp_offset == 3'd2) ? hwdata_i[g_width-1:0] : '0;

  always_ff @(posedge hclk_i or posedge rst_i) begin
    if (rst_i) begin
      out_reg  <= '0;
      debounce <= g_debounce_default;
      edge_reg <= '0;
    end else begin
      if (wr && dp_offset == 3'd0) out_reg <= hwdata_i[g_width-1:0];
      if (wr && dp_offset == 3'd3) debounce <= hwdata_i[15:0];
      // A new rising edge wins over a simultaneous write-one-to-clear.
      edge_reg <= (edge_reg & ~edge_clr) | edge_set;
    end
  end

  always_ff @(posedge hclk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1  <= '0;
      s      <= '0;
      smp    <= '0;
      in_reg <= '0;
      cnt    <= g_debounce_default;
    end else begin
      sync1 <= gpio_i;
      s     <= sync1;
      if (wr && dp_offset == 3'd3) cnt <= hwdata_i[15:0];
      else if (tick)               cnt <= debounce;
      else                         cnt <= cnt - 16'd1;
      // A bit is accepted only when it matched at two consecutive ticks.
      if (tick) begin
        smp    <= s;
        in_reg <= (s & match) | (in_reg & ~match);
      end
    end
  end

`ifdef GPIO_IRQ_EN
  always_ff @(posedge hclk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_mask <= '0;
      irq_o    <= 1'b0;
    end else begin
      if (wr && dp_offset == 3'd5) irq_mask <= hwdata_i[g_width-1:0];
      irq_o <= |(edge_reg & irq_mask);
    end
  end
`endif

  always_comb begin
    hrdata_o = '0;
    if (dp_valid && !dp_write) begin
      case (dp_offset)
        3'd0: hrdata_o[g_width-1:0] = out_reg;
        3'd1: hrdata_o[g_width-1:0] = in_reg;
        3'd2: hrdata_o[g_width-1:0] = edge_reg;
        3'd3: hrdata_o[15:0]        = debounce;
        3'd4: hrdata_o              = g_hdata_size'(g_id);
`ifdef GPIO_IRQ_EN
        3'd5: hrdata_o[g_width-1:0] = irq_mask;
`endif
        default: hrdata_o = '0;
      endcase
    end
  end

  assign gpio_o = out_reg;

endmodule

// File: tb/tb_ahb3lite_gpio.sv
// Directed self-checking bench for ahb3lite_gpio (single-slave bus, HREADY tied to HREADYOUT).
module tb_ahb3lite_gpio;

  logic        hclk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [31:0] hrdata;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [2:0]  hburst = 3'b000;
  logic [3:0]  hprot = 4'b0011;
  logic [1:0]  htrans = 2'b00;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
`ifdef GPIO_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        rdy;
  logic        resp;

  assign hready = hreadyout;

  ahb3lite_gpio dut (
    .hclk_i      (hclk),
    .rst_i       (rst),
    .hsel_i      (hsel),
    .haddr_i     (haddr),
    .hwdata_i    (hwdata),
    .hrdata_o    (hrdata),
    .hwrite_i    (hwrite),
    .hsize_i     (hsize),
    .hburst_i    (hburst),
    .hprot_i     (hprot),
    .htrans_i    (htrans),
    .hready_i    (hready),
    .hreadyout_o (hreadyout),
    .hresp_o     (hresp),
    .gpio_i      (gpio_in),
    .gpio_o      (gpio_out)
`ifdef GPIO_IRQ_EN
    ,
    .irq_o       (irq)
`endif
  );

  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic r, output logic e);
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010;
    tick_n(1);
    hsel = 1'b0; htrans = 2'b00;
    data = hrdata; r = hreadyout; e = hresp;
    tick_n(1);
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic r, output logic e);
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    tick_n(1);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = data;
    r = hreadyout; e = hresp;
    tick_n(1);
  endtask

  // Drives one illegal transfer and checks the two-cycle ERROR response.
  task automatic err_seq(input string tag, input logic [31:0] addr, input logic wr_en,
                         input logic [2:0] size, input logic [31:0] data);
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr_en; hsize = size;
    tick_n(1);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hwdata = data;
    check({tag, "_err1"}, 32'({hreadyout, hresp}), 32'b01);
    tick_n(1);
    check({tag, "_err2"}, 32'({hreadyout, hresp}), 32'b11);
    tick_n(1);
    check({tag, "_idle"}, 32'({hreadyout, hresp}), 32'b10);
  endtask

  initial begin
    $display("[TB] start");
    tick_n(2);
    check("rst_ready", 32'({hreadyout, hresp}), 32'b10);
    check("rst_rdata", hrdata, 32'h0);
    check("rst_gpio", 32'(gpio_out), 32'h0);
    rst = 1'b0;
    tick_n(1);

    ahb_read(32'h10, rd, rdy, resp);
    check("id_data", rd, 32'h6770_0001);
    check("id_okay", 32'({rdy, resp}), 32'b10);
    ahb_read(32'h00, rd, rdy, resp);
    check("out_reset", rd, 32'h0);
    ahb_read(32'h0C, rd, rdy, resp);
    check("deb_reset", rd, 32'h0000_270F);

    // OUT write: gpio_o changes only at the edge ending the data phase.
    hsel = 1'b1; haddr = 32'h00; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
    tick_n(1);
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0000_00A5;
    check("out_before", 32'(gpio_out), 32'h00);
    check("out_dp_ready", 32'(hreadyout), 32'h1);
    tick_n(1);
    check("out_after", 32'(gpio_out), 32'hA5);
    ahb_read(32'h00, rd, rdy, resp);
    check("out_readback", rd, 32'h0000_00A5);
    check("out_rd_ready", 32'(rdy), 32'h1);

    ahb_write(32'h0C, 32'h0, rdy, resp);
    gpio_in[0] = 1'b1;
    tick_n(3);
    check("in_edge3", 32'(dut.in_reg), 32'h00);
    tick_n(1);
    check("in_edge4", 32'(dut.in_reg), 32'h01);
    check("edge_edge4", 32'(dut.edge_reg), 32'h01);

    gpio_in[1] = 1'b1;
    tick_n(1);
    gpio_in[1] = 1'b0;
    tick_n(6);
    check("glitch_in", 32'(dut.in_reg), 32'h01);
    check("glitch_edge", 32'(dut.edge_reg), 32'h01);
    ahb_read(32'h04, rd, rdy, resp);
    check("in_read", rd, 32'h01);
    ahb_read(32'h08, rd, rdy, resp);
    check("edge_read", rd, 32'h01);

    gpio_in[0] = 1'b0;
    tick_n(6);
    check("fall_in", 32'(dut.in_reg), 32'h00);
    check("fall_edge_sticky", 32'(dut.edge_reg), 32'h01);
    // The W1C data phase ends on edge 4, the same edge IN[0] rises again.
    gpio_in[0] = 1'b1;
    tick_n(2);
    ahb_write(32'h08, 32'h01, rdy, resp);
    check("setwins_in", 32'(dut.in_reg), 32'h01);
    check("setwins_edge", 32'(dut.edge_reg), 32'h01);
    ahb_write(32'h08, 32'h01, rdy, resp);
    check("w1c_edge", 32'(dut.edge_reg), 32'h00);
    ahb_read(32'h08, rd, rdy, resp);
    check("w1c_read", rd, 32'h00);

    err_seq("rd18", 32'h18, 1'b0, 3'b010, 32'h0);
    err_seq("bytewr", 32'h00, 1'b1, 3'b000, 32'h0000_00FF);
    check("bytewr_out", 32'(gpio_out), 32'hA5);

    ahb_write(32'h10, 32'h0, rdy, resp);
    check("ro_wr_okay", 32'({rdy, resp}), 32'b10);
    ahb_read(32'h10, rd, rdy, resp);
    check("ro_id_kept", rd, 32'h6770_0001);

`ifdef GPIO_IRQ_EN
    ahb_write(32'h14, 32'h02, rdy, resp);
    ahb_read(32'h14, rd, rdy, resp);
    check("mask_read", rd, 32'h02);
    gpio_in[1] = 1'b1;
    tick_n(4);
    check("irq_edge_set", 32'(dut.edge_reg), 32'h02);
    check("irq_not_yet", 32'(irq), 32'h0);
    tick_n(1);
    check("irq_high", 32'(irq), 32'h1);
    ahb_write(32'h08, 32'h02, rdy, resp);
    check("irq_edge_clr", 32'(dut.edge_reg), 32'h00);
    check("irq_lag", 32'(irq), 32'h1);
    tick_n(1);
    check("irq_low", 32'(irq), 32'h0);
`else
    err_seq("rd14", 32'h14, 1'b0, 3'b010, 32'h0);
`endif

    ahb_write(32'h0C, 32'h3, rdy, resp);
    ahb_read(32'h0C, rd, rdy, resp);
    check("deb_write", rd, 32'h3);
    check("idle_rdata", hrdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
